// File: rtl/dp_sequencer_pkg.sv
// Shared state encoding and instruction-field definitions for the run/step sequencer.
package dp_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

    localparam int         OP_HI         = 7;
    localparam int         OP_LO         = 6;
    localparam logic [1:0] OP_JUMP       = 2'b11;
    localparam logic [5:0] SELF_JUMP_OFS = 6'b111111;

    // A jump whose offset field is all ones targets itself: the program has ended.
    function automatic logic is_self_jump(input logic [7:0] instr);
        return (instr[OP_HI:OP_LO] == OP_JUMP) && (instr[OP_LO-1:0] == SELF_JUMP_OFS);
    endfunction

endpackage

// File: rtl/dp_seq_timeout.sv
// Loadable down-counter; expire_o is high once the count has drained to zero.
module dp_seq_timeout #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/dp_sequencer.sv
// Run/step controller: fetches one instruction per grant from a handshaked ROM at the
// datapath PC and strobes dp_en for exactly one cycle per executed instruction.
module dp_sequencer
    import dp_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             _CLK,
    input  logic             _RESET,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    input  logic [7:0]       pc,
    output logic [7:0]       imem_addr,
    output logic             imem_rd,
    input  logic [7:0]       imem_data,
    input  logic             imem_valid,
    output logic [7:0]       instruction,
    output logic             dp_en,
    output logic             running,
    output logic             halted,
    output logic             fault,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned      TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    seq_state_e       state_q;
    logic             single_q;
    logic             bp_skip_q;
    logic             bp_hit_q;
    logic             fault_q;
    logic [7:0]       instr_q;
    logic [7:0]       addr_q;
    logic [CNT_W-1:0] count_q;

    logic bp_stop;
    logic fetch_go;
    logic tmo_expire;

    // bp_skip lets the resume after a breakpoint execute the instruction it stopped on.
    assign bp_stop  = bp_en && (pc == bp_addr) && !bp_skip_q;
    assign fetch_go = (state_q == ST_FETCH) && !bp_stop;

    dp_seq_timeout #(
        .W (TMO_W)
    ) u_timeout (
        .clk        (_CLK),
        .rst_n      (_RESET),
        .load_i     (fetch_go),
        .load_val_i (TMO_LOAD),
        .en_i       (state_q == ST_WAIT),
        .expire_o   (tmo_expire)
    );

    always_ff @(posedge _CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q   <= ST_IDLE;
            single_q  <= 1'b0;
            bp_skip_q <= 1'b0;
            bp_hit_q  <= 1'b0;
            fault_q   <= 1'b0;
            instr_q   <= 8'h00;
            addr_q    <= 8'h00;
            count_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (step) begin
                        single_q <= 1'b1;
                        state_q  <= ST_FETCH;
                    end else if (run && !halt_req) begin
                        single_q <= 1'b0;
                        state_q  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (bp_stop) begin
                        bp_hit_q  <= 1'b1;
                        bp_skip_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        addr_q   <= pc;
                        bp_hit_q <= 1'b0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid) begin
                        instr_q <= imem_data;
                        state_q <= ST_EXEC;
                    end else if (tmo_expire) begin
                        fault_q <= 1'b1;
                        state_q <= ST_HALT;
                    end
                end
                ST_EXEC: begin
                    if (count_q != CNT_MAX) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                    bp_skip_q <= 1'b0;
                    if (is_self_jump(instr_q)) begin
                        state_q <= ST_HALT;
                    end else if (halt_req || single_q || !run) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The read goes out during FETCH with the live PC, which the datapath has just updated.
    assign imem_rd     = fetch_go;
    assign imem_addr   = (state_q == ST_FETCH) ? pc : addr_q;
    assign instruction = instr_q;
    assign dp_en       = (state_q == ST_EXEC);
    assign running     = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT);
    assign fault       = fault_q;
    assign bp_hit      = bp_hit_q;
    assign instr_count = count_q;

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Run/step controller for the 8-bit single-cycle datapath.
- Fetches each instruction from a handshaked instruction memory at the datapath's current PC and presents it on `instruction`.
- Issues a one-cycle commit enable `dp_en` so the datapath executes exactly one instruction per grant.
- Supports free-run, single-step, breakpoint, self-jump halt detection and memory-timeout fault; sits between the board buttons/switches, the instruction ROM and the datapath.

Parameters:
- MEM_TIMEOUT, 8: max cycles waited in WAIT for imem_valid before faulting.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- _CLK  in  1  system clock, rising edge.
- _RESET  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = free-run.
- step  in  1  single-cycle pulse; execute one instruction.
- halt_req  in  1  level; stop at next instruction boundary.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  8  breakpoint PC.
- pc  in  8  current PC from datapath.
- imem_addr  out  8  instruction memory address.
- imem_rd  out  1  one-cycle read request.
- imem_data  in  8  read data.
- imem_valid  in  1  read data valid.
- instruction  out  8  instruction to datapath, held between fetches.
- dp_en  out  1  one-cycle commit strobe to datapath.
- running  out  1  high in FETCH/WAIT/EXEC.
- halted  out  1  high in HALT.
- fault  out  1  sticky memory-timeout flag.
- bp_hit  out  1  high while stopped at breakpoint.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (async, _RESET=0): state IDLE.
  - imem_addr=0, imem_rd=0, instruction=8'h00, dp_en=0.
  - running=0, halted=0, fault=0, bp_hit=0, instr_count=0, single=0, bp_skip=0.
  - Reset mid-operation aborts any outstanding read; a late imem_valid is ignored.
- States: IDLE, FETCH, WAIT, EXEC, HALT.
- IDLE:
  - step=1 → single=1, go FETCH.
  - else run=1 and halt_req=0 → single=0, go FETCH.
  - step and run both high → treat as step.
- FETCH (one cycle):
  - If bp_en and pc==bp_addr and bp_skip=0 → bp_hit=1, bp_skip=1, go IDLE, no read.
  - Otherwise drive imem_addr=pc, imem_rd=1, clear bp_hit, go WAIT.
  - bp_skip guarantees the resume after a breakpoint executes the breakpoint instruction.
- WAIT:
  - imem_rd=0, imem_addr held.
  - Timeout counter starts at 0 on entry.
  - On imem_valid: latch instruction<=imem_data, go EXEC.
  - Counter reaching MEM_TIMEOUT without valid → fault=1, go HALT.
  - imem_valid in any other state is ignored.
- EXEC (one cycle):
  - dp_en=1; datapath updates PC on the rising edge ending EXEC.
  - instr_count+1, saturating at all-ones.
  - bp_skip cleared.
  - Next state, priority order:
    - Self-jump (instruction[7:6]==2'b11 and instruction[5:0]==6'b111111) → HALT.
    - halt_req=1 or single=1 or run=0 → IDLE.
    - Else → FETCH.
- Minimum latency: FETCH→WAIT→EXEC = 3 cycles per instruction with 1-cycle memory; dp_en never asserts on consecutive cycles.
- HALT:
  - halted=1, no outputs toggle.
  - Exit only by reset.
- step pulses while running are ignored.
- Inputs are assumed synchronous to _CLK; debouncing is done upstream.

Decomposition:
- Shared package/include:
  - State encoding constants.
  - Opcode field positions: OP_HI=7, OP_LO=6.
  - OP_JUMP=2'b11, SELF_JUMP_OFS=6'b111111.
- Natural sub-module: dp_seq_timeout (loadable down-counter with expire flag), used by WAIT.
- Everything else stays flat.

Test Plan:
- 1-cycle-latency ROM, program {71,4D,74,B7,05,FF} at 0..5; pulse step once → exactly one dp_en, instruction=8'h71, instr_count=1, back in IDLE, pc advances to 1.
- Same program, run=1 → six dp_en pulses with instructions 71,4D,74,B7,05,FF in order; after FF (self-jump), halted=1, running=0, instr_count=6, no further imem_rd.
- bp_en=1, bp_addr=3, run=1 → stops with bp_hit=1 after instr_count=3, no read at address 3; keep run, toggle to re-enter → next dp_en carries B7, bp_hit clears.
- ROM never asserts imem_valid → fault=1 and halted=1 exactly MEM_TIMEOUT(8) cycles after WAIT entry; dp_en never asserted.
- Drop _RESET while in WAIT, then assert imem_valid with data 8'hAA → all outputs at reset values, instruction stays 8'h00, state IDLE.
- Run with halt_req raised during WAIT → current instruction completes (one dp_en), then IDLE; release halt_req with run=1 → fetching resumes at new pc.
